// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared op codes, forwarding selects and funct3 values for the execute stage
package ex_stage_pkg;

    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;
    localparam logic [3:0] ALU_SLL   = 4'h2;
    localparam logic [3:0] ALU_SLT   = 4'h3;
    localparam logic [3:0] ALU_SLTU  = 4'h4;
    localparam logic [3:0] ALU_XOR   = 4'h5;
    localparam logic [3:0] ALU_SRL   = 4'h6;
    localparam logic [3:0] ALU_SRA   = 4'h7;
    localparam logic [3:0] ALU_OR    = 4'h8;
    localparam logic [3:0] ALU_AND   = 4'h9;
    localparam logic [3:0] ALU_PASSB = 4'hA;
    localparam logic [3:0] ALU_PCB   = 4'hB;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ex_divider.sv
// rtl/ex_divider.sv - iterative radix-2 restoring divider with sign fix-up and special cases
module ex_divider
    import ex_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_flush,
    input  logic            i_start,
    input  logic            i_signed,
    input  logic            i_rem_sel,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(DIV_ITERS);
    localparam logic [CW-1:0] LAST_ITER = CW'(DIV_ITERS - 1);

    div_state_e      r_state;
    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_div;
    logic [CW-1:0]   r_cnt;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_rem_sel;

    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_ovf;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_fit;

    assign w_a_neg = i_signed & i_a[XLEN-1];
    assign w_b_neg = i_signed & i_b[XLEN-1];
    assign w_a_mag = w_a_neg ? (~i_a + 1'b1) : i_a;
    assign w_b_mag = w_b_neg ? (~i_b + 1'b1) : i_b;
    assign w_ovf   = i_signed && (i_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_b == '1);

    // Partial remainder stays below the divisor, so a 33-bit difference is enough:
    // its top bit is set exactly when the divisor does not fit.
    assign w_shift = {r_rem, r_quot[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_div};
    assign w_fit   = ~w_diff[XLEN];

    assign o_busy   = ((r_state == DIV_IDLE) && i_start) || (r_state == DIV_BUSY);
    assign o_done   = (r_state == DIV_DONE);
    assign o_result = r_rem_sel ? (r_neg_r ? (~r_rem + 1'b1) : r_rem)
                                : (r_neg_q ? (~r_quot + 1'b1) : r_quot);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= DIV_IDLE;
            r_quot    <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_cnt     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_rem_sel <= 1'b0;
        end else if (i_flush) begin
            r_state <= DIV_IDLE;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (i_start) begin
                        r_rem_sel <= i_rem_sel;
                        r_cnt     <= '0;
                        if (i_b == '0) begin
                            r_quot  <= '1;
                            r_rem   <= i_a;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_state <= DIV_DONE;
                        end else if (w_ovf) begin
                            r_quot  <= i_a;
                            r_rem   <= '0;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_state <= DIV_DONE;
                        end else begin
                            r_quot  <= w_a_mag;
                            r_rem   <= '0;
                            r_div   <= w_b_mag;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                            r_state <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    r_rem  <= w_fit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
                    r_quot <= {r_quot[XLEN-2:0], w_fit};
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) begin
                        r_state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    r_state <= DIV_IDLE;
                end
                default: begin
                    r_state <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - RV32IM execute stage with forwarding, ALU, branch compare, MUL, DIV and EX/MEM register
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flushE,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            MemtoRegE,
    input  logic            branchE,
    input  logic            mdEnE,
    input  logic            ALUSrcE,
    input  logic [3:0]      ALUCtrlE,
    input  logic [2:0]      strCtrlE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] r1E,
    input  logic [XLEN-1:0] r2E,
    input  logic [XLEN-1:0] immE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] ResultW,
    input  logic [4:0]      rdE,
    output logic            busyE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic            MemtoRegM,
    output logic            branchM,
    output logic            PCBranchM,
    output logic [2:0]      strCtrlM,
    output logic [XLEN-1:0] ALUoutM,
    output logic [XLEN-1:0] PCplusImmM,
    output logic [XLEN-1:0] r2M,
    output logic [4:0]      rdM
);

    logic [XLEN-1:0]   w_src_a;
    logic [XLEN-1:0]   w_fwd_b;
    logic [XLEN-1:0]   w_src_b;
    logic [4:0]        w_shamt;
    logic [XLEN-1:0]   w_alu;
    logic              w_br_eq;
    logic              w_br_lt;
    logic              w_br_ltu;
    logic              w_br_taken;
    logic              w_mul_a_sgn;
    logic              w_mul_b_sgn;
    logic [2*XLEN-1:0] w_mul_a;
    logic [2*XLEN-1:0] w_mul_b;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul;
    logic              w_div_start;
    logic              w_div_signed;
    logic              w_div_rem;
    logic              w_div_done;
    logic [XLEN-1:0]   w_div_result;
    logic [XLEN-1:0]   w_ex_result;

    always_comb begin
        case (ForwardAE)
            FWD_WB:  w_src_a = ResultW;
            FWD_MEM: w_src_a = ALUoutM;
            default: w_src_a = r1E;
        endcase
        case (ForwardBE)
            FWD_WB:  w_fwd_b = ResultW;
            FWD_MEM: w_fwd_b = ALUoutM;
            default: w_fwd_b = r2E;
        endcase
    end

    assign w_src_b = ALUSrcE ? immE : w_fwd_b;
    assign w_shamt = w_src_b[4:0];

    always_comb begin
        case (ALUCtrlE)
            ALU_ADD:   w_alu = w_src_a + w_src_b;
            ALU_SUB:   w_alu = w_src_a - w_src_b;
            ALU_SLL:   w_alu = w_src_a << w_shamt;
            ALU_SLT:   w_alu = {{(XLEN-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
            ALU_SLTU:  w_alu = {{(XLEN-1){1'b0}}, (w_src_a < w_src_b)};
            ALU_XOR:   w_alu = w_src_a ^ w_src_b;
            ALU_SRL:   w_alu = w_src_a >> w_shamt;
            ALU_SRA:   w_alu = $signed(w_src_a) >>> w_shamt;
            ALU_OR:    w_alu = w_src_a | w_src_b;
            ALU_AND:   w_alu = w_src_a & w_src_b;
            ALU_PASSB: w_alu = w_src_b;
            ALU_PCB:   w_alu = PCE + w_src_b;
            default:   w_alu = '0;
        endcase
    end

    // Branches compare the two register operands, never the immediate.
    assign w_br_eq  = (w_src_a == w_fwd_b);
    assign w_br_lt  = ($signed(w_src_a) < $signed(w_fwd_b));
    assign w_br_ltu = (w_src_a < w_fwd_b);

    always_comb begin
        case (strCtrlE)
            F3_BEQ:  w_br_taken = w_br_eq;
            F3_BNE:  w_br_taken = ~w_br_eq;
            F3_BLT:  w_br_taken = w_br_lt;
            F3_BGE:  w_br_taken = ~w_br_lt;
            F3_BLTU: w_br_taken = w_br_ltu;
            F3_BGEU: w_br_taken = ~w_br_ltu;
            default: w_br_taken = 1'b0;
        endcase
    end

    // Extending both operands to 64 bits lets one unsigned multiply serve all signedness mixes.
    assign w_mul_a_sgn = (strCtrlE == F3_MULH) || (strCtrlE == F3_MULHSU);
    assign w_mul_b_sgn = (strCtrlE == F3_MULH);
    assign w_mul_a     = {{XLEN{w_mul_a_sgn & w_src_a[XLEN-1]}}, w_src_a};
    assign w_mul_b     = {{XLEN{w_mul_b_sgn & w_fwd_b[XLEN-1]}}, w_fwd_b};
    assign w_prod      = w_mul_a * w_mul_b;

    always_comb begin
        case (strCtrlE)
            F3_MUL:    w_mul = w_prod[XLEN-1:0];
            F3_MULH,
            F3_MULHSU,
            F3_MULHU:  w_mul = w_prod[2*XLEN-1:XLEN];
            default:   w_mul = '0;
        endcase
    end

    assign w_div_start  = mdEnE & strCtrlE[2] & ~flushE & ~rst;
    assign w_div_signed = (strCtrlE == F3_DIV) || (strCtrlE == F3_REM);
    assign w_div_rem    = (strCtrlE == F3_REM) || (strCtrlE == F3_REMU);

    ex_divider #(
        .XLEN      (XLEN),
        .DIV_ITERS (DIV_ITERS)
    ) u_divider (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (flushE),
        .i_start   (w_div_start),
        .i_signed  (w_div_signed),
        .i_rem_sel (w_div_rem),
        .i_a       (w_src_a),
        .i_b       (w_fwd_b),
        .o_busy    (busyE),
        .o_done    (w_div_done),
        .o_result  (w_div_result)
    );

    assign w_ex_result = w_div_done ? w_div_result : (mdEnE ? w_mul : w_alu);

    always_ff @(posedge clk) begin
        if (rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            branchM    <= 1'b0;
            PCBranchM  <= 1'b0;
            strCtrlM   <= '0;
            ALUoutM    <= '0;
            PCplusImmM <= '0;
            r2M        <= '0;
            rdM        <= '0;
        end else if (flushE || busyE) begin
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
            MemtoRegM <= 1'b0;
            branchM   <= 1'b0;
            PCBranchM <= 1'b0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            MemtoRegM  <= MemtoRegE;
            branchM    <= branchE;
            PCBranchM  <= w_br_taken;
            strCtrlM   <= strCtrlE;
            ALUoutM    <= w_ex_result;
            PCplusImmM <= PCE + immE;
            r2M        <= w_fwd_b;
            rdM        <= rdE;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard bench for the execute stage
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flushE, RegWriteE, MemWriteE, MemtoRegE, branchE, mdEnE, ALUSrcE;
    logic [3:0]  ALUCtrlE;
    logic [2:0]  strCtrlE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] r1E, r2E, immE, PCE, ResultW;
    logic [4:0]  rdE;
    logic        busyE, RegWriteM, MemWriteM, MemtoRegM, branchM, PCBranchM;
    logic [2:0]  strCtrlM;
    logic [31:0] ALUoutM, PCplusImmM, r2M;
    logic [4:0]  rdM;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] r2;
        logic [31:0] pci;
        logic [6:0]  ctl;
        logic        chk_br;
        logic        br;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ex_stage #(.XLEN(32), .DIV_ITERS(32)) dut (
        .clk(clk), .rst(rst), .flushE(flushE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE), .branchE(branchE),
        .mdEnE(mdEnE), .ALUSrcE(ALUSrcE), .ALUCtrlE(ALUCtrlE), .strCtrlE(strCtrlE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .r1E(r1E), .r2E(r2E), .immE(immE), .PCE(PCE), .ResultW(ResultW), .rdE(rdE),
        .busyE(busyE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
        .branchM(branchM), .PCBranchM(PCBranchM), .strCtrlM(strCtrlM),
        .ALUoutM(ALUoutM), .PCplusImmM(PCplusImmM), .r2M(r2M), .rdM(rdM)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic nop();
        {RegWriteE, MemWriteE, MemtoRegE, branchE, mdEnE, ALUSrcE, flushE} = '0;
        ALUCtrlE = '0; strCtrlE = '0; ForwardAE = '0; ForwardBE = '0;
        r1E = '0; r2E = '0; immE = '0; PCE = '0; ResultW = '0; rdE = '0;
    endtask

    task automatic issue(input logic [3:0] ctl, input logic md, input logic alusrc,
                         input logic [3:0] aluc, input logic [2:0] f3,
                         input logic [1:0] fa, input logic [1:0] fb,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [31:0] resw, input logic [4:0] rd,
                         input logic [31:0] e_alu, input logic [31:0] e_r2,
                         input logic chk, input logic e_br);
        exp_t e;
        {RegWriteE, MemWriteE, MemtoRegE, branchE} = ctl;
        mdEnE = md; ALUSrcE = alusrc; ALUCtrlE = aluc; strCtrlE = f3;
        ForwardAE = fa; ForwardBE = fb; flushE = 1'b0;
        r1E = r1; r2E = r2; immE = imm; PCE = pc; ResultW = resw; rdE = rd;
        e.rd = rd; e.alu = e_alu; e.r2 = e_r2; e.pci = pc + imm;
        e.ctl = {ctl, f3}; e.chk_br = chk; e.br = e_br;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic alu_op(input logic [3:0] aluc, input logic alusrc, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] imm, input logic [4:0] rd,
                          input logic [31:0] e_alu);
        issue(4'b1000, 1'b0, alusrc, aluc, 3'b000, 2'b00, 2'b00, r1, r2, imm, 32'h0, 32'h0,
              rd, e_alu, r2, 1'b0, 1'b0);
    endtask

    task automatic br_op(input logic [2:0] f3, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] e_alu, input logic e_br);
        issue(4'b0001, 1'b0, 1'b0, 4'h1, f3, 2'b00, 2'b00, r1, r2, imm, pc, 32'h0,
              5'd0, e_alu, r2, 1'b1, e_br);
    endtask

    task automatic mul_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] e_res);
        issue(4'b1000, 1'b1, 1'b0, 4'h0, f3, 2'b00, 2'b00, a, b, 32'h0, 32'h0, 32'h0,
              rd, e_res, b, 1'b0, 1'b0);
    endtask

    task automatic div_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] e_res, input int e_busy);
        exp_t e;
        int   cnt;
        logic bub;
        nop();
        RegWriteE = 1'b1; mdEnE = 1'b1; strCtrlE = f3; r1E = a; r2E = b; rdE = rd;
        e.rd = rd; e.alu = e_res; e.r2 = b; e.pci = 32'h0;
        e.ctl = {4'b1000, f3}; e.chk_br = 1'b0; e.br = 1'b0;
        q.push_back(e);
        #1;
        cnt = 0;
        bub = 1'b1;
        while (busyE && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            if (RegWriteM || MemWriteM || branchM) bub = 1'b0;
        end
        check("div_busy_cycles", cnt, e_busy);
        check("div_stall_bubbles", {31'b0, bub}, 32'h1);
        @(posedge clk); #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_ctrl"}, {19'b0, RegWriteM, MemWriteM, MemtoRegM, branchM, PCBranchM,
                               strCtrlM, rdM}, 32'h0);
        check({tag, "_aluout"}, ALUoutM, 32'h0);
        check({tag, "_pcimm"}, PCplusImmM, 32'h0);
        check({tag, "_r2m"}, r2M, 32'h0);
        check({tag, "_busy"}, {31'b0, busyE}, 32'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (RegWriteM || MemWriteM || branchM)) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got rd %0d aluout 0x%08h expected none",
                             rdM, ALUoutM);
                end else begin
                    e = q.pop_front();
                    check("aluout", ALUoutM, e.alu);
                    check("rd", {27'b0, rdM}, {27'b0, e.rd});
                    check("r2m", r2M, e.r2);
                    check("pcplusimm", PCplusImmM, e.pci);
                    check("ctrl", {25'b0, RegWriteM, MemWriteM, MemtoRegM, branchM, strCtrlM},
                          {25'b0, e.ctl});
                    if (e.chk_br) check("pcbranch", {31'b0, PCBranchM}, {31'b0, e.br});
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        nop();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        rst = 1'b0;

        alu_op(4'h0, 1'b0, 32'd7, 32'hFFFF_FFFF, 32'h0, 5'd1, 32'd6);
        alu_op(4'h7, 1'b1, 32'h8000_0000, 32'h0, 32'd4, 5'd2, 32'hF800_0000);
        alu_op(4'h3, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 5'd6, 32'd1);
        alu_op(4'h4, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 5'd7, 32'd0);
        alu_op(4'hA, 1'b1, 32'h0, 32'h0, 32'h1234_5000, 5'd8, 32'h1234_5000);
        issue(4'b1000, 1'b0, 1'b1, 4'hB, 3'b000, 2'b00, 2'b00, 32'h0, 32'h0, 32'h1000,
              32'h200, 32'h0, 5'd9, 32'h1200, 32'h0, 1'b0, 1'b0);

        br_op(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 32'hFFFF_FFFE, 1'b1);
        br_op(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 32'hFFFF_FFFE, 1'b0);
        br_op(3'b001, 32'd5, 32'd5, 32'h40, 32'h8, 32'h0, 1'b0);
        br_op(3'b111, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0, 32'h20, 32'hFFFF_FFFE, 1'b1);

        alu_op(4'h0, 1'b1, 32'd5, 32'h0, 32'h0, 5'd3, 32'd5);
        issue(4'b1000, 1'b0, 1'b1, 4'h0, 3'b000, 2'b10, 2'b00, 32'd9, 32'h0, 32'd1,
              32'h0, 32'h0, 5'd4, 32'd6, 32'h0, 1'b0, 1'b0);
        issue(4'b1000, 1'b0, 1'b1, 4'h0, 3'b000, 2'b01, 2'b00, 32'd9, 32'h0, 32'd1,
              32'h0, 32'd3, 5'd5, 32'd4, 32'h0, 1'b0, 1'b0);
        issue(4'b0100, 1'b0, 1'b1, 4'h0, 3'b010, 2'b00, 2'b10, 32'h1000, 32'h99, 32'd8,
              32'h0, 32'h0, 5'd0, 32'h1008, 32'd4, 1'b0, 1'b0);

        mul_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd10, 32'hFFFF_FFEB);
        mul_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd11, 32'h4000_0000);
        mul_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFF);
        mul_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'hFFFF_FFFE);

        div_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd14, 32'hFFFF_FFFD, 33);
        div_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd15, 32'hFFFF_FFFF, 33);
        div_op(3'b101, 32'd100, 32'd7, 5'd16, 32'd14, 33);
        div_op(3'b101, 32'h1234, 32'h0, 5'd17, 32'hFFFF_FFFF, 1);
        div_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 1);
        div_op(3'b110, 32'hFFFF_FFF9, 32'h0, 5'd19, 32'hFFFF_FFF9, 1);
        nop();

        RegWriteE = 1'b1; mdEnE = 1'b1; strCtrlE = 3'b100; r1E = 32'd100; r2E = 32'd7;
        rdE = 5'd25;
        repeat (10) @(posedge clk);
        #1;
        flushE = 1'b1;
        @(posedge clk); #1;
        nop();
        #1;
        check("flush_busy", {31'b0, busyE}, 32'h0);
        check("flush_bubble", {31'b0, RegWriteM}, 32'h0);
        alu_op(4'h0, 1'b0, 32'd10, 32'd20, 32'h0, 5'd20, 32'd30);
        nop();

        RegWriteE = 1'b1; mdEnE = 1'b1; strCtrlE = 3'b101; r1E = 32'd100; r2E = 32'd7;
        rdE = 5'd26;
        repeat (5) @(posedge clk);
        #1;
        nop();
        rst = 1'b1;
        @(posedge clk); #1;
        check_cleared("rst_mid_div");
        rst = 1'b0;
        alu_op(4'h0, 1'b0, 32'd1, 32'd2, 32'h0, 5'd21, 32'd3);
        nop();

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
